// File: rtl/led_channel_scanner.sv
// LED channel scanner: shows one of CHANNELS packed WIDTH-bit sources on the
// LED bank, with manual stepping, timed auto rotation and a freeze snapshot.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   data_in    packed sources, channel k at [k*WIDTH +: WIDTH]
//   step       one-cycle advance pulse (already debounced)
//   mode_auto  1 = timed rotation, 0 = manual stepping
//   freeze     level, 1 = browse the snapshot instead of live data
//   leds       registered value of the displayed channel
//   chan       registered index of the displayed channel
//   frozen     registered, high while the snapshot is shown

module led_channel_scanner #(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 25000000,
    localparam int SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      step,
    input  logic                      mode_auto,
    input  logic                      freeze,
    output logic [WIDTH-1:0]          leds,
    output logic [SEL_W-1:0]          chan,
    output logic                      frozen
);

    localparam int CNT_W = $clog2(DWELL);

    typedef enum logic [1:0] {
        S_MANUAL = 2'd0,
        S_AUTO   = 2'd1,
        S_FROZEN = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_next;
    logic [CHANNELS*WIDTH-1:0] r_snap;
    logic [WIDTH-1:0]          r_leds;
    logic [SEL_W-1:0]          r_chan;
    logic                      r_frozen;

    logic                      w_term;
    logic                      w_adv;
    logic [SEL_W-1:0]          w_next_chan;
    logic                      w_take_snap;
    logic                      w_use_snap;
    logic [CHANNELS*WIDTH-1:0] w_src_bus;
    logic [WIDTH-1:0]          w_src;

    // Next state: freeze wins over mode_auto from every state.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_FROZEN: begin
                if (!freeze) begin
                    w_next_state = mode_auto ? S_AUTO : S_MANUAL;
                end
            end
            default: begin
                if (freeze) begin
                    w_next_state = S_FROZEN;
                end else begin
                    w_next_state = mode_auto ? S_AUTO : S_MANUAL;
                end
            end
        endcase
    end

    // Channel advance; step and terminal count together advance only once.
    always_comb begin
        w_term      = (r_state == S_AUTO) && (r_cnt == CNT_W'(DWELL - 1));
        w_adv       = step || w_term;
        w_next_chan = r_chan;
        if (w_adv) begin
            if (r_chan == SEL_W'(CHANNELS - 1)) begin
                w_next_chan = '0;
            end else begin
                w_next_chan = r_chan + SEL_W'(1);
            end
        end
    end

    // Dwell counter only runs while staying in AUTO.
    always_comb begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if ((w_next_state != r_state) || (r_state != S_AUTO) || w_adv) begin
            w_cnt_next = '0;
        end
    end

    // The snapshot is read only once it is loaded and still wanted; on the
    // entry edge the live data equals what is being captured, and on the
    // exit edge live data is shown immediately.
    always_comb begin
        w_take_snap = freeze && (r_state != S_FROZEN);
        w_use_snap  = (r_state == S_FROZEN) && (w_next_state == S_FROZEN);
        w_src_bus   = w_use_snap ? r_snap : data_in;
    end

    always_comb begin
        w_src = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_next_chan == SEL_W'(k)) begin
                w_src = w_src_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_MANUAL;
            r_cnt    <= '0;
            r_snap   <= '0;
            r_leds   <= '0;
            r_chan   <= '0;
            r_frozen <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_cnt_next;
            r_leds   <= w_src;
            r_chan   <= w_next_chan;
            r_frozen <= (w_next_state == S_FROZEN);
            if (w_take_snap) begin
                r_snap <= data_in;
            end
        end
    end

    assign leds   = r_leds;
    assign chan   = r_chan;
    assign frozen = r_frozen;

endmodule

// File: tb/tb_led_channel_scanner.sv
// Directed scoreboard bench for led_channel_scanner.
// Instance A: 4 x 4-bit, DWELL=4. Instance B: 3 x 8-bit, DWELL=4.

module tb_led_channel_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_a;
    logic        step_a;
    logic        mode_a;
    logic        freeze_a;
    logic [3:0]  leds_a;
    logic [1:0]  chan_a;
    logic        frozen_a;

    logic [23:0] data_b;
    logic        step_b;
    logic        mode_b;
    logic        freeze_b;
    logic [7:0]  leds_b;
    logic [1:0]  chan_b;
    logic        frozen_b;

    always #5 clk = ~clk;

    led_channel_scanner #(
        .WIDTH(4), .CHANNELS(4), .DWELL(4)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .data_in(data_a), .step(step_a),
        .mode_auto(mode_a), .freeze(freeze_a), .leds(leds_a),
        .chan(chan_a), .frozen(frozen_a)
    );

    led_channel_scanner #(
        .WIDTH(8), .CHANNELS(3), .DWELL(4)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(data_b), .step(step_b),
        .mode_auto(mode_b), .freeze(freeze_b), .leds(leds_b),
        .chan(chan_b), .frozen(frozen_b)
    );

    typedef struct {
        string       tag;
        logic [31:0] leds;
        logic [31:0] chan;
        logic        frz;
        bit          is_b;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_chan = 0;
    int   exp_cnt = 0;
    int   exp_b = 0;

    task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] nib(logic [15:0] d, int c);
        return d[c*4 +: 4];
    endfunction

    function automatic logic [7:0] byt(logic [23:0] d, int c);
        return d[c*8 +: 8];
    endfunction

    task automatic push(string tag, logic [31:0] l, logic [31:0] c,
                        logic f, bit b);
        exp_t e;
        e.tag  = tag;
        e.leds = l;
        e.chan = c;
        e.frz  = f;
        e.is_b = b;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL sb_underflow observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            if (e.is_b) begin
                cmp({e.tag, "_leds"}, 32'(leds_b), e.leds);
                cmp({e.tag, "_chan"}, 32'(chan_b), e.chan);
                cmp({e.tag, "_frz"}, 32'(frozen_b), 32'(e.frz));
            end else begin
                cmp({e.tag, "_leds"}, 32'(leds_a), e.leds);
                cmp({e.tag, "_chan"}, 32'(chan_a), e.chan);
                cmp({e.tag, "_frz"}, 32'(frozen_a), 32'(e.frz));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_man(string tag);
        step_a = 1'b1;
        exp_chan = (exp_chan + 1) % 4;
        push(tag, 32'(nib(data_a, exp_chan)), 32'(exp_chan), 1'b0, 1'b0);
        tick();
        step_a = 1'b0;
        pop_check();
    endtask

    task automatic auto_tick(logic s, string tag);
        bit adv;
        adv = s || (exp_cnt == 3);
        step_a = s;
        if (adv) begin
            exp_chan = (exp_chan + 1) % 4;
            exp_cnt  = 0;
        end else begin
            exp_cnt++;
        end
        push(tag, 32'(nib(data_a, exp_chan)), 32'(exp_chan), 1'b0, 1'b0);
        tick();
        step_a = 1'b0;
        pop_check();
    endtask

    task automatic check_reset_now(string tag);
        push(tag, 32'd0, 32'd0, 1'b0, 1'b0);
        pop_check();
        push({tag, "_b"}, 32'd0, 32'd0, 1'b0, 1'b1);
        pop_check();
    endtask

    initial begin
        rst_n    = 1'b0;
        data_a   = 16'h4321;
        step_a   = 1'b0;
        mode_a   = 1'b0;
        freeze_a = 1'b0;
        data_b   = 24'hC3B2A1;
        step_b   = 1'b0;
        mode_b   = 1'b0;
        freeze_b = 1'b0;

        #12;
        check_reset_now("reset");
        rst_n = 1'b1;
        tick();
        push("idle", 32'h1, 32'd0, 1'b0, 1'b0);
        pop_check();

        for (int i = 0; i < 5; i++) begin
            step_man("man_step");
        end

        data_a = 16'h4331;
        push("live_pre", 32'h3, 32'(exp_chan), 1'b0, 1'b0);
        tick();
        pop_check();
        data_a = 16'h4391;
        push("live_9", 32'h9, 32'(exp_chan), 1'b0, 1'b0);
        tick();
        pop_check();
        data_a = 16'h4321;
        tick();

        mode_a  = 1'b1;
        exp_cnt = 0;
        push("auto_enter", 32'(nib(data_a, exp_chan)), 32'(exp_chan),
             1'b0, 1'b0);
        tick();
        pop_check();
        for (int k = 0; k < 16; k++) begin
            auto_tick(1'b0, "auto_rot");
        end
        for (int k = 0; k < 3; k++) begin
            auto_tick(1'b0, "auto_pre_tc");
        end
        auto_tick(1'b1, "auto_step_tc");
        for (int k = 0; k < 4; k++) begin
            auto_tick(1'b0, "auto_after_tc");
        end
        auto_tick(1'b1, "auto_step_mid");
        auto_tick(1'b0, "auto_cnt1");
        auto_tick(1'b0, "auto_cnt2");

        #2;
        rst_n = 1'b0;
        #1;
        check_reset_now("rst_auto");
        #2;
        mode_a = 1'b0;
        rst_n  = 1'b1;
        exp_chan = 0;
        tick();
        push("post_rst_auto", 32'h1, 32'd0, 1'b0, 1'b0);
        pop_check();
        tick();
        push("post_rst_hold", 32'h1, 32'd0, 1'b0, 1'b0);
        pop_check();
        step_man("to_chan1");
        step_man("to_chan2");

        freeze_a = 1'b1;
        push("frz_enter", 32'h3, 32'd2, 1'b1, 1'b0);
        tick();
        pop_check();
        data_a = 16'hFFFF;
        push("frz_hold", 32'h3, 32'd2, 1'b1, 1'b0);
        tick();
        pop_check();
        step_a = 1'b1;
        push("frz_step", 32'h4, 32'd3, 1'b1, 1'b0);
        tick();
        step_a = 1'b0;
        pop_check();
        freeze_a = 1'b0;
        push("frz_drop", 32'hF, 32'd3, 1'b0, 1'b0);
        tick();
        pop_check();

        freeze_a = 1'b1;
        push("frz2", 32'hF, 32'd3, 1'b1, 1'b0);
        tick();
        pop_check();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_now("rst_frz");
        #2;
        freeze_a = 1'b0;
        data_a   = 16'h4321;
        rst_n    = 1'b1;
        exp_chan = 0;
        tick();
        push("post_rst_frz", 32'h1, 32'd0, 1'b0, 1'b0);
        pop_check();
        step_man("post_rst_step");

        push("b_idle", 32'(byt(data_b, 0)), 32'd0, 1'b0, 1'b1);
        pop_check();
        for (int i = 0; i < 7; i++) begin
            step_b = 1'b1;
            exp_b  = (exp_b + 1) % 3;
            push("b_step", 32'(byt(data_b, exp_b)), 32'(exp_b), 1'b0, 1'b1);
            tick();
            step_b = 1'b0;
            pop_check();
            cmp("b_not3", 32'(chan_b == 2'd3), 32'd0);
        end
        step_b = 1'b1;
        exp_b  = (exp_b + 1) % 3;
        push("b_hold_step", 32'(byt(data_b, exp_b)), 32'(exp_b), 1'b0, 1'b1);
        tick();
        pop_check();
        exp_b = (exp_b + 1) % 3;
        push("b_hold_step2", 32'(byt(data_b, exp_b)), 32'(exp_b), 1'b0, 1'b1);
        tick();
        step_b = 1'b0;
        pop_check();

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_channel_scanner.md
Name: led_channel_scanner

Overview:
- Parametrised successor of the four-way LED display selector.
- Selects one of CHANNELS packed W-bit values (numerator, denominator, quotient, remainder, and any extra channels) and drives the LED bank with it, registered.
- Channel selection is either manual, advanced by a debounced step pulse, or automatic rotation with a programmable dwell time.
- A freeze mode snapshots all channels so the operator can browse stable values while the sources keep changing.

Parameters:
- WIDTH, 4, bit width of each channel and of the LED output.
- CHANNELS, 4, number of input channels (>=2; need not be a power of two).
- DWELL, 25000000, clock cycles per channel in auto mode (>=2).
- SEL_W (localparam), max(1, clog2(CHANNELS)), width of the channel index.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  CHANNELS*WIDTH  packed sources; channel k occupies bits [k*WIDTH +: WIDTH].
- step  input  1  one-cycle pulse from the debouncer; advance to the next channel.
- mode_auto  input  1  1 = automatic rotation, 0 = manual stepping.
- freeze  input  1  level; 1 = display snapshot values instead of live data.
- leds  output  WIDTH  registered value of the selected channel.
- chan  output  SEL_W  registered index of the displayed channel.
- frozen  output  1  registered; 1 while in the FROZEN state.

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-low.
- While rst_n=0: leds=0, chan=0, frozen=0, dwell counter=0, snapshot registers=0, state=MANUAL.

FSM states:
- MANUAL, AUTO and FROZEN; state updates each rising clk edge.
- From MANUAL or AUTO: freeze=1 -> FROZEN. At that same edge, all CHANNELS values of data_in are copied into the snapshot registers.
- Else, from MANUAL or AUTO: mode_auto=1 -> AUTO; mode_auto=0 -> MANUAL.
- From FROZEN: freeze=0 -> AUTO if mode_auto=1, else MANUAL. No new snapshot is taken while in FROZEN.
- freeze takes priority over mode_auto.

Channel advance:
- Next index = chan+1, wrapping to 0 after CHANNELS-1.
- Codes >= CHANNELS are never produced.
- MANUAL: advance on each cycle where step=1.
- AUTO: the dwell counter increments every cycle. When it reaches DWELL-1: advance, and reset the counter to 0. A step pulse in AUTO also advances and resets the counter. Step and terminal count in the same cycle advance by exactly one.
- FROZEN: advance on step only. The dwell counter is held at 0.
- The dwell counter is cleared on every state change.
- chan is retained across all mode changes; it is never reset except by rst_n.

Output path:
- leds <= source[next_chan] each cycle, where source is data_in in MANUAL/AUTO and the snapshot in FROZEN.
- Latency: a change on data_in (live modes) or on chan appears on leds 1 cycle later. leds and chan always correspond to each other.
- On the edge entering FROZEN, leds shows the captured value of the current channel, so the display does not glitch.
- frozen is registered together with the state.

Other rules:
- step pulses longer than one cycle advance once per high cycle; de-bouncing is upstream.
- Reset asserted mid-rotation or mid-freeze forces the reset values immediately; operation resumes in MANUAL at channel 0.

Test Plan:
1. Reset and manual stepping (CHANNELS=4, WIDTH=4): data_in=16'h4321, mode_auto=0, then 5 single-cycle step pulses. Required after reset: leds=0, chan=0. Required after each pulse: chan=1,2,3,0,1 with leds=2,3,4,1,2, each one cycle after its pulse.
2. Auto rotation (DWELL=4): hold mode_auto=1 for 16 cycles. chan must advance every 4 cycles: 0->1->2->3->0. A step on the cycle the counter reaches 3 must produce exactly one advance.
3. Freeze: at chan=2 with data_in=16'h4321, raise freeze, then change data_in to 16'hFFFF.
   - leds must stay 3 and frozen=1.
   - A step must give chan=3, leds=4 (snapshot value).
   - Dropping freeze must give leds=F on the next cycle.
4. Non-power-of-two width and count (CHANNELS=3, WIDTH=8): step repeatedly. chan must cycle 0,1,2,0 and never take the value 3. leds must equal the matching byte of data_in.
5. Reset mid-operation: in AUTO with the counter at 2, or in FROZEN, pulse rst_n=0 for a non-clock-aligned 3 ns. All outputs must go to 0 immediately. After release, the block must behave as MANUAL at channel 0.
6. Live tracking: in MANUAL at chan=1, change channel 1 from 3 to 9. leds must show 9 exactly one cycle later.
